control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the 32-bit RISC datapath. It steps each instruction through fetch (T0–T2) and execute (T3–T7) and drives the datapath strobes. That includes the Gra/Grb/Grc/Rin/Rout/BAout selects consumed by the register select-and-encode stage. Opcode comes from IR[31:27]. A conditional branch resolves from the registered CON_FF result.

## Interface
- No parameters. Opcodes, ALU codes and states are constants in cpu_pkg.
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- IR  in  32  instruction register contents; stable from the end of T2 until the next T2
- CON_FF  in  1  branch-condition flip-flop output
- PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, Read, Write, IRin, CONin, Cout  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/enable controls
- alu_op  out  4  ADD=0, SUB=1, AND=2, OR=3; 0 when Zin is low
- Run  out  1  high while executing; low in RESET and HALT

## Operation
Opcodes:
- ld=00000, ldi=00001, st=00010
- add=00011, sub=00100, and=00101, or=00110
- addi=01100, andi=01101, ori=01110
- br=10011, jr=10100, jal=10101
- nop=11010, halt=11011
- Any other opcode behaves as nop.

States: RESET, T0–T7, HALT. Each state lasts one cycle. Strobes not listed for a step are 0.

Fetch:
- T0: PCout, MARin, IncPC, Zin, alu_op=ADD
- T1: Zlowout, PCin, Read, MDRin
- T2: MDRout, IRin

Execute:
- add/sub/and/or:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, alu_op per opcode
  - T5: Zlowout, Gra, Rin
- addi/andi/ori: as above, except T4 uses Cout instead of Grc/Rout, with alu_op ADD/AND/OR.
- ldi:
  - T3: Grb, BAout, Yin
  - T4: Cout, Zin, ADD
  - T5: Zlowout, Gra, Rin
- ld:
  - T3–T4 as ldi
  - T5: Zlowout, MARin
  - T6: Read, MDRin
  - T7: MDRout, Gra, Rin
- st:
  - T3–T5 as ld
  - T6: Gra, Rout, MDRin (Read low)
  - T7: Write
- br:
  - T3: Gra, Rout, CONin
  - T4: PCout, Yin
  - T5: Cout, Zin, ADD
  - T6: Zlowout; PCin only if CON_FF=1
- jr:
  - T3: Gra, Rout, PCin
- jal:
  - T3: PCout, Grb, Rin (link written to the RB-field register)
  - T4: Gra, Rout, PCin
- nop/illegal: no execute steps; T2 goes directly to T0.
- halt: T2 goes to HALT and stays there until reset_n is low; all strobes are 0 and Run=0.

Transitions:
- RESET goes to T0 on the first clock after reset_n deasserts.
- The last step of each instruction goes to T0.

Invariants:
- At most one of Gra/Grb/Grc is high in any cycle.
- Rin and Rout are never both high.
- BAout only occurs with Grb.

## Timing
- Moore outputs: all strobes are decoded combinationally from the state register plus IR[31:27]. Only the state register is clocked.
- Asynchronous reset forces RESET immediately, including mid-instruction (e.g. during a st T7). All outputs are 0 and Run=0 in RESET; no partial Write or Rin pulse may follow.
- Cycle counts, including fetch:
  - add/addi/ldi: 6 cycles
  - ld/st: 8 cycles
  - br: 7 cycles
  - jr: 4 cycles
  - jal: 5 cycles
  - nop: 3 cycles
- CON_FF is sampled only in br T6. It must reflect the CONin load at the T3 clock edge.
- IR changes only at the T2 edge. Decode during T0–T2 uses the previous IR, but fetch strobes do not depend on the opcode.

## Structure
- cpu_pkg holds:
  - opcode localparams (5-bit)
  - alu_op codes (4-bit)
  - state encoding (4-bit: RESET, T0–T7, HALT)
- One sub-module, op_class_decode. It maps IR[31:27] to a one-hot class: alu_r, alu_i, ld, ldi, st, br, jr, jal, nop, halt. The sequencer uses the class to choose execute steps and alu_op.

## Test plan
- reset_n low mid-T4 of add → all outputs 0 and Run=0 in the same cycle; after release, T0 on the next edge, then PCout, MARin, IncPC, Zin.
- IR=0x18918000 (add R1,R2,R3) → T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with alu_op=0, T5 Gra/Rin, T0 at cycle 6.
- st (opcode 00010, RA=3, RB=4) → BAout only in T3, Write only in T7, Read never high after T1, return to T0 after 8 cycles.
- br with CON_FF=0, then br with CON_FF=1 → PCin low in T6 for the first and high in T6 for the second; 7 cycles each.
- jal (RA=5, RB=15) → T3 PCout/Grb/Rin, T4 Gra/Rout/PCin, T0 next.
- opcode 11111, then halt → the first returns to T0 after T2; halt holds HALT with Run=0 for 20 cycles until reset_n is low.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the hardwired control unit: opcodes, ALU codes,
// sequencer states, the decoded opcode class and the bundle of control strobes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic ld;
    logic ldi;
    logic st;
    logic br;
    logic jr;
    logic jal;
    logic nop;
    logic halt;
  } op_class_t;

  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       pc_in;
    logic       z_in;
    logic       zlow_out;
    logic       y_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       read;
    logic       write;
    logic       ir_in;
    logic       con_in;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic [3:0] alu_op;
    logic       run;
  } ctrl_t;

  // Immediate forms share the ALU code of their register-register counterparts.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Maps the 5-bit opcode to a one-hot instruction class; unknown opcodes decode as nop.
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output op_class_t  o_class
);

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    o_class = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: o_class.alu_r = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:      o_class.alu_i = 1'b1;
      OP_LD:                         o_class.ld    = 1'b1;
      OP_LDI:                        o_class.ldi   = 1'b1;
      OP_ST:                         o_class.st    = 1'b1;
      OP_BR:                         o_class.br    = 1'b1;
      OP_JR:                         o_class.jr    = 1'b1;
      OP_JAL:                        o_class.jal   = 1'b1;
      OP_HALT:                       o_class.halt  = 1'b1;
      default:                       o_class.nop   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, execute T3-T7, decoded from the
// state register and the opcode class of IR[31:27].
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Yin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        CONin,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  alu_op,
  output logic        Run
);

  state_t    r_state;
  state_t    w_next_state;
  op_class_t w_class;
  ctrl_t     w_ctrl;
  logic      w_unused_ir;

  // Register fields are consumed by the select-and-encode stage, not here.
  assign w_unused_ir = ^IR[26:0];

  op_class_decode u_decode (
    .i_opcode (IR[31:27]),
    .o_class  (w_class)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset_n) r_state <= S_RESET;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET: w_next_state = S_T0;
      S_T0:    w_next_state = S_T1;
      S_T1:    w_next_state = S_T2;
      S_T2:    w_next_state = w_class.halt ? S_HALT : (w_class.nop ? S_T0 : S_T3);
      S_T3:    w_next_state = w_class.jr ? S_T0 : S_T4;
      S_T4:    w_next_state = w_class.jal ? S_T0 : S_T5;
      S_T5:    w_next_state = (w_class.alu_r || w_class.alu_i || w_class.ldi) ? S_T0 : S_T6;
      S_T6:    w_next_state = w_class.br ? S_T0 : S_T7;
      S_T7:    w_next_state = S_T0;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RESET;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.inc_pc = 1'b1;
        w_ctrl.z_in   = 1'b1; w_ctrl.alu_op = ALU_ADD;
      end
      S_T1: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in  = 1'b1;
        w_ctrl.read     = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        if (w_class.alu_r || w_class.alu_i) begin
          w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.ld || w_class.ldi || w_class.st) begin
          w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.br) begin
          w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1;
        end else if (w_class.jr) begin
          w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1;
        end else if (w_class.jal) begin
          w_ctrl.pc_out = 1'b1; w_ctrl.grb = 1'b1; w_ctrl.r_in = 1'b1;
        end
      end
      S_T4: begin
        if (w_class.alu_r) begin
          w_ctrl.grc  = 1'b1; w_ctrl.r_out  = 1'b1;
          w_ctrl.z_in = 1'b1; w_ctrl.alu_op = alu_code(IR[31:27]);
        end else if (w_class.alu_i) begin
          w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = alu_code(IR[31:27]);
        end else if (w_class.ld || w_class.ldi || w_class.st) begin
          w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = ALU_ADD;
        end else if (w_class.br) begin
          w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.jal) begin
          w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1;
        end
      end
      S_T5: begin
        if (w_class.alu_r || w_class.alu_i || w_class.ldi) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
        end else if (w_class.ld || w_class.st) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
        end else if (w_class.br) begin
          w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = ALU_ADD;
        end
      end
      S_T6: begin
        if (w_class.ld) begin
          w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
        end else if (w_class.st) begin
          w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.mdr_in = 1'b1;
        end else if (w_class.br) begin
          // CON_FF was loaded at the T3 edge, so it is settled by now.
          w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = CON_FF;
        end
      end
      S_T7: begin
        if (w_class.ld) begin
          w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
        end else if (w_class.st) begin
          w_ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
    w_ctrl.run = (r_state != S_RESET) && (r_state != S_HALT);
  end

  assign PCout   = w_ctrl.pc_out;
  assign MARin   = w_ctrl.mar_in;
  assign IncPC   = w_ctrl.inc_pc;
  assign PCin    = w_ctrl.pc_in;
  assign Zin     = w_ctrl.z_in;
  assign Zlowout = w_ctrl.zlow_out;
  assign Yin     = w_ctrl.y_in;
  assign MDRin   = w_ctrl.mdr_in;
  assign MDRout  = w_ctrl.mdr_out;
  assign Read    = w_ctrl.read;
  assign Write   = w_ctrl.write;
  assign IRin    = w_ctrl.ir_in;
  assign CONin   = w_ctrl.con_in;
  assign Cout    = w_ctrl.c_out;
  assign Gra     = w_ctrl.gra;
  assign Grb     = w_ctrl.grb;
  assign Grc     = w_ctrl.grc;
  assign Rin     = w_ctrl.r_in;
  assign Rout    = w_ctrl.r_out;
  assign BAout   = w_ctrl.ba_out;
  assign alu_op  = w_ctrl.alu_op;
  assign Run     = w_ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-step strobe vectors for each instruction
// class, cycle counts, asynchronous reset mid-instruction and halt.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] IR;
  logic        CON_FF;
  logic PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, Read, Write;
  logic IRin, CONin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Run;
  logic [3:0] alu_op;

  int n_vec = 0;
  int n_err = 0;
  int inv_bad = 0;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Zin(Zin),
    .Zlowout(Zlowout), .Yin(Yin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
    .Write(Write), .IRin(IRin), .CONin(CONin), .Cout(Cout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .Run(Run)
  );

  always #5 clock = ~clock;

  // {Run, alu_op, 20 strobes}
  logic [24:0] obs;
  assign obs = {Run, alu_op, PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout,
                Read, Write, IRin, CONin, Cout, Gra, Grb, Grc, Rin, Rout, BAout};

  localparam logic [24:0] B_RUN     = 25'd1 << 24;
  localparam logic [24:0] A_SUB     = 25'd1 << 20;
  localparam logic [24:0] A_AND     = 25'd2 << 20;
  localparam logic [24:0] A_OR      = 25'd3 << 20;
  localparam logic [24:0] B_PCOUT   = 25'd1 << 19;
  localparam logic [24:0] B_MARIN   = 25'd1 << 18;
  localparam logic [24:0] B_INCPC   = 25'd1 << 17;
  localparam logic [24:0] B_PCIN    = 25'd1 << 16;
  localparam logic [24:0] B_ZIN     = 25'd1 << 15;
  localparam logic [24:0] B_ZLOWOUT = 25'd1 << 14;
  localparam logic [24:0] B_YIN     = 25'd1 << 13;
  localparam logic [24:0] B_MDRIN   = 25'd1 << 12;
  localparam logic [24:0] B_MDROUT  = 25'd1 << 11;
  localparam logic [24:0] B_READ    = 25'd1 << 10;
  localparam logic [24:0] B_WRITE   = 25'd1 << 9;
  localparam logic [24:0] B_IRIN    = 25'd1 << 8;
  localparam logic [24:0] B_CONIN   = 25'd1 << 7;
  localparam logic [24:0] B_COUT    = 25'd1 << 6;
  localparam logic [24:0] B_GRA     = 25'd1 << 5;
  localparam logic [24:0] B_GRB     = 25'd1 << 4;
  localparam logic [24:0] B_GRC     = 25'd1 << 3;
  localparam logic [24:0] B_RIN     = 25'd1 << 2;
  localparam logic [24:0] B_ROUT    = 25'd1 << 1;
  localparam logic [24:0] B_BAOUT   = 25'd1 << 0;

  localparam logic [24:0] F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [24:0] F1 = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [24:0] F2 = B_RUN | B_MDROUT | B_IRIN;

  // Register-select invariants watched on every cycle.
  always @(negedge clock) begin
    if ((int'(Gra) + int'(Grb) + int'(Grc)) > 1 || (Rin && Rout) || (BAout && !Grb))
      inv_bad++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; IR = 32'h0; CON_FF = 1'b0;
    #1;
    n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", obs, 25'd0); end
    step(); step();
    n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs, 25'd0); end
    reset_n = 1'b1;
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL reset_to_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_add();
    logic [24:0] exp [6];
    exp = '{F0, F1, F2, B_RUN|B_GRB|B_ROUT|B_YIN, B_RUN|B_GRC|B_ROUT|B_ZIN,
            B_RUN|B_ZLOWOUT|B_GRA|B_RIN};
    IR = 32'h18918000;
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (obs !== exp[i]) begin n_err++; $display("FAIL add T%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL add_return_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops [6];
    logic [24:0] t4  [6];
    ops = '{5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110};
    t4  = '{B_RUN|B_GRC|B_ROUT|B_ZIN|A_SUB, B_RUN|B_GRC|B_ROUT|B_ZIN|A_AND,
            B_RUN|B_GRC|B_ROUT|B_ZIN|A_OR,  B_RUN|B_COUT|B_ZIN,
            B_RUN|B_COUT|B_ZIN|A_AND,       B_RUN|B_COUT|B_ZIN|A_OR};
    for (int k = 0; k < 6; k++) begin
      IR = {ops[k], 27'h0};
      for (int i = 0; i < 4; i++) step();
      n_vec++; if (obs !== t4[k]) begin n_err++; $display("FAIL alu_op%0d T4: got %h expected %h", k, obs, t4[k]); end
      step(); step();
      n_vec++; if (obs !== F0) begin n_err++; $display("FAIL alu_op%0d return_t0: got %h expected %h", k, obs, F0); end
    end
  endtask

  task automatic test_load();
    logic [24:0] exp [8];
    exp = '{F0, F1, F2, B_RUN|B_GRB|B_BAOUT|B_YIN, B_RUN|B_COUT|B_ZIN,
            B_RUN|B_ZLOWOUT|B_MARIN, B_RUN|B_READ|B_MDRIN, B_RUN|B_MDROUT|B_GRA|B_RIN};
    IR = 32'h01A00000;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (obs !== exp[i]) begin n_err++; $display("FAIL ld T%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL ld_return_t0: got %h expected %h", obs, F0); end
    IR = 32'h09A00000;
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (obs !== (B_RUN|B_ZLOWOUT|B_GRA|B_RIN)) begin
      n_err++; $display("FAIL ldi T5: got %h expected %h", obs, B_RUN|B_ZLOWOUT|B_GRA|B_RIN);
    end
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL ldi_return_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_store();
    logic [24:0] exp [8];
    exp = '{F0, F1, F2, B_RUN|B_GRB|B_BAOUT|B_YIN, B_RUN|B_COUT|B_ZIN,
            B_RUN|B_ZLOWOUT|B_MARIN, B_RUN|B_GRA|B_ROUT|B_MDRIN, B_RUN|B_WRITE};
    IR = 32'h11A00000;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (obs !== exp[i]) begin n_err++; $display("FAIL st T%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL st_return_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_branch(input logic con);
    logic [24:0] exp [7];
    exp = '{F0, F1, F2, B_RUN|B_GRA|B_ROUT|B_CONIN, B_RUN|B_PCOUT|B_YIN,
            B_RUN|B_COUT|B_ZIN, B_RUN|B_ZLOWOUT|(con ? B_PCIN : 25'd0)};
    IR = 32'h98800000; CON_FF = con;
    for (int i = 0; i < 7; i++) begin
      n_vec++; if (obs !== exp[i]) begin n_err++; $display("FAIL br(con=%0d) T%0d: got %h expected %h", con, i, obs, exp[i]); end
      step();
    end
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL br(con=%0d) return_t0: got %h expected %h", con, obs, F0); end
    CON_FF = 1'b0;
  endtask

  task automatic test_jumps();
    logic [24:0] exp [5];
    IR = 32'hA1000000;
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (obs !== (B_RUN|B_GRA|B_ROUT|B_PCIN)) begin
      n_err++; $display("FAIL jr T3: got %h expected %h", obs, B_RUN|B_GRA|B_ROUT|B_PCIN);
    end
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL jr_return_t0: got %h expected %h", obs, F0); end
    exp = '{F0, F1, F2, B_RUN|B_PCOUT|B_GRB|B_RIN, B_RUN|B_GRA|B_ROUT|B_PCIN};
    IR = 32'hAAF80000;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (obs !== exp[i]) begin n_err++; $display("FAIL jal T%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL jal_return_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_nop_illegal();
    logic [31:0] irs [2];
    irs = '{32'hF8000000, 32'hD0000000};
    for (int k = 0; k < 2; k++) begin
      IR = irs[k];
      step();
      n_vec++; if (obs !== F1) begin n_err++; $display("FAIL nop%0d T1: got %h expected %h", k, obs, F1); end
      step();
      n_vec++; if (obs !== F2) begin n_err++; $display("FAIL nop%0d T2: got %h expected %h", k, obs, F2); end
      step();
      n_vec++; if (obs !== F0) begin n_err++; $display("FAIL nop%0d return_t0: got %h expected %h", k, obs, F0); end
    end
  endtask

  task automatic test_reset_mid();
    IR = 32'h18918000;
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (obs !== (B_RUN|B_GRC|B_ROUT|B_ZIN)) begin
      n_err++; $display("FAIL mid_add T4: got %h expected %h", obs, B_RUN|B_GRC|B_ROUT|B_ZIN);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL mid_add_reset: got %h expected %h", obs, 25'd0); end
    step();
    reset_n = 1'b1;
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL mid_add_restart: got %h expected %h", obs, F0); end
    IR = 32'h11A00000;
    for (int i = 0; i < 7; i++) step();
    n_vec++; if (obs !== (B_RUN|B_WRITE)) begin n_err++; $display("FAIL mid_st T7: got %h expected %h", obs, B_RUN|B_WRITE); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL mid_st_reset: got %h expected %h", obs, 25'd0); end
    step();
    n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL mid_st_no_write: got %h expected %h", obs, 25'd0); end
    reset_n = 1'b1;
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL mid_st_restart: got %h expected %h", obs, F0); end
  endtask

  task automatic test_halt();
    IR = 32'hD8000000;
    step(); step();
    n_vec++; if (obs !== F2) begin n_err++; $display("FAIL halt T2: got %h expected %h", obs, F2); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_vec++; if (obs !== 25'd0) begin n_err++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, 25'd0); end
    end
    reset_n = 1'b0;
    step();
    IR = 32'h0;
    reset_n = 1'b1;
    step();
    n_vec++; if (obs !== F0) begin n_err++; $display("FAIL halt_reset_to_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_invariants();
    n_vec++; if (inv_bad !== 0) begin n_err++; $display("FAIL select_invariants: got %0d violations expected 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load();
    test_store();
    test_branch(1'b0);
    test_branch(1'b1);
    test_jumps();
    test_nop_illegal();
    test_reset_mid();
    test_halt();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
